// File: rtl/acp_mm2s_cmd_engine.sv
// MM2S command engine: takes one 72-bit read command at a time, issues 4 KB-safe AXI4 INCR
// bursts on the ACP read port, streams beats out, then returns a status byte. Stats: ACP_MM2S_STATS_EN.
`timescale 1ns/1ps

module acp_mm2s_cmd_engine #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_MAX_BURST        = 16,
  parameter logic [2:0]  C_PROT             = 3'b010,
  parameter logic [3:0]  C_CACHE            = 4'b1111
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [71:0]                   S_AXIS_CMD_TDATA,
  input  logic                          S_AXIS_CMD_TVALID,
  output logic                          S_AXIS_CMD_TREADY,
  output logic [7:0]                    M_AXIS_STS_TDATA,
  output logic                          M_AXIS_STS_TVALID,
  input  logic                          M_AXIS_STS_TREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [31:0]                   stat_bytes,
  output logic [15:0]                   stat_cmds
);

  localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BEAT_W = 20;
  localparam int unsigned BLEN_W = 5;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, STATUS} state_t;

  state_t              state;
  state_t              state_next;

  logic [AW-1:0]       addr;
  logic [BEAT_W-1:0]   beats_left;
  logic                eof;
  logic [3:0]          tag;
  logic                slverr;
  logic                decerr;
  logic                interr;
  logic [BLEN_W-1:0]   burst_len;
  logic [BLEN_W-1:0]   beat_cnt;
  logic                cmd_tready;
  logic                arvalid;
  logic [AW-1:0]       araddr;
  logic [7:0]          arlen;
  logic                sts_tvalid;
  logic [7:0]          sts_tdata;

  logic [22:0]         cmd_btt;
  logic [31:0]         cmd_saddr;
  logic                cmd_bad;
  logic                cmd_fire;
  logic                ar_fire;
  logic                r_fire;
  logic                sts_fire;
  logic                burst_last;
  logic                final_burst;
  logic [9:0]          room_beats;
  logic [BEAT_W-1:0]   len_c;
  logic                unused_cmd_bits;

  // Command field decode and handshake qualifiers
  assign cmd_btt         = S_AXIS_CMD_TDATA[22:0];
  assign cmd_saddr       = S_AXIS_CMD_TDATA[63:32];
  assign cmd_bad         = (cmd_btt == 23'd0) || (cmd_saddr[2:0] != 3'd0) || (cmd_btt[2:0] != 3'd0);
  assign cmd_fire        = (state == IDLE) && S_AXIS_CMD_TVALID && cmd_tready;
  assign ar_fire         = arvalid && M_AXI_ARREADY;
  assign r_fire          = (state == DATA) && M_AXI_RVALID && M_AXIS_TREADY;
  assign sts_fire        = sts_tvalid && M_AXIS_STS_TREADY;
  assign burst_last      = (beat_cnt == burst_len - BLEN_W'(1));
  assign final_burst     = (beats_left == BEAT_W'(burst_len));
  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31], S_AXIS_CMD_TDATA[29:23]};

  // Burst length: limited by max burst, remaining beats and distance to the next 4 KB page
  always_comb begin
    room_beats = 10'((13'h1000 - {1'b0, addr[11:0]}) >> 3);
    len_c      = beats_left;
    if (len_c > BEAT_W'(room_beats)) len_c = BEAT_W'(room_beats);
    if (len_c > BEAT_W'(C_MAX_BURST)) len_c = BEAT_W'(C_MAX_BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = cmd_bad ? STATUS : ADDR;
      ADDR:    if (ar_fire) state_next = DATA;
      DATA:    if (r_fire && burst_last) state_next = final_burst ? STATUS : ADDR;
      STATUS:  if (sts_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command context, AR channel, error flags and status register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      beats_left <= '0;
      eof        <= 1'b0;
      tag        <= 4'd0;
      slverr     <= 1'b0;
      decerr     <= 1'b0;
      interr     <= 1'b0;
      burst_len  <= '0;
      beat_cnt   <= '0;
      cmd_tready <= 1'b1;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= 8'd0;
      sts_tvalid <= 1'b0;
      sts_tdata  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cmd_tready <= 1'b0;
            addr       <= AW'(cmd_saddr);
            beats_left <= cmd_btt[22:3];
            eof        <= S_AXIS_CMD_TDATA[30];
            tag        <= S_AXIS_CMD_TDATA[67:64];
            interr     <= cmd_bad;
          end
        end
        ADDR: begin
          if (!arvalid) begin
            arvalid   <= 1'b1;
            araddr    <= addr;
            arlen     <= 8'(len_c - BEAT_W'(1));
            burst_len <= BLEN_W'(len_c);
            beat_cnt  <= '0;
          end else if (M_AXI_ARREADY) begin
            arvalid <= 1'b0;
          end
        end
        DATA: begin
          if (r_fire) begin
            if (M_AXI_RRESP == 2'b10) slverr <= 1'b1;
            if (M_AXI_RRESP == 2'b11) decerr <= 1'b1;
            // RLAST from the slave is only checked; the burst ends on our own count
            if (M_AXI_RLAST != burst_last) interr <= 1'b1;
            if (burst_last) begin
              beat_cnt   <= '0;
              addr       <= addr + AW'({burst_len, 3'b000});
              beats_left <= beats_left - BEAT_W'(burst_len);
            end else begin
              beat_cnt <= beat_cnt + BLEN_W'(1);
            end
          end
        end
        STATUS: begin
          if (!sts_tvalid) begin
            sts_tvalid <= 1'b1;
            sts_tdata  <= {!(slverr | decerr | interr), slverr, decerr, interr, tag};
          end else if (M_AXIS_STS_TREADY) begin
            sts_tvalid <= 1'b0;
            slverr     <= 1'b0;
            decerr     <= 1'b0;
            interr     <= 1'b0;
            cmd_tready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXIS_CMD_TREADY = cmd_tready;
  assign M_AXIS_STS_TDATA  = sts_tdata;
  assign M_AXIS_STS_TVALID = sts_tvalid;

  assign M_AXI_ARADDR  = araddr;
  assign M_AXI_ARLEN   = arlen;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = C_CACHE;
  assign M_AXI_ARPROT  = C_PROT;
  assign M_AXI_ARVALID = arvalid;

  // Zero-latency pass-through of read beats while a burst is in flight
  assign M_AXI_RREADY  = (state == DATA) && M_AXIS_TREADY;
  assign M_AXIS_TVALID = (state == DATA) && M_AXI_RVALID;
  assign M_AXIS_TDATA  = M_AXI_RDATA;
  assign M_AXIS_TLAST  = (state == DATA) && eof && final_burst && burst_last;

`ifdef ACP_MM2S_STATS_EN
  logic [31:0] bytes_q;
  logic [15:0] cmds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q <= 32'd0;
      cmds_q  <= 16'd0;
    end else begin
      if (r_fire) bytes_q <= bytes_q + 32'd8;
      if (sts_fire && (state == STATUS)) cmds_q <= cmds_q + 16'd1;
    end
  end

  assign stat_bytes = bytes_q;
  assign stat_cmds  = cmds_q;
`else
  assign stat_bytes = 32'd0;
  assign stat_cmds  = 16'd0;
`endif

endmodule

// File: doc/acp_mm2s_cmd_engine.md
Name: acp_mm2s_cmd_engine

Overview:
- Responder for the 72-bit command / 8-bit status stream pair that the stream-master control blocks drive.
- Accepts one read command at a time and issues AXI4 INCR read bursts on the ACP master read channel.
- Forwards returned beats as a 64-bit AXI stream toward the custom hardware, then returns a status byte.
- Sits between the h2s command/status wires and the M_AXI_AR*/R* port of the accelerator top.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: ACP address width.
- C_M_AXI_DATA_WIDTH, 64: ACP/stream data width; only 64 is supported (8-byte beats).
- C_MAX_BURST, 16: max beats per burst (1..16, ACP limit).
- C_PROT, 3'b010: driven on M_AXI_ARPROT.
- C_CACHE, 4'b1111: driven on M_AXI_ARCACHE.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- S_AXIS_CMD_TDATA  in  72  command: [22:0] BTT bytes, [30] EOF, [63:32] SADDR, [67:64] TAG; other bits ignored.
- S_AXIS_CMD_TVALID  in  1 / S_AXIS_CMD_TREADY  out  1: command handshake.
- M_AXIS_STS_TDATA  out  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
- M_AXIS_STS_TVALID  out  1 / M_AXIS_STS_TREADY  in  1: status handshake.
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH; M_AXI_ARLEN out 8; M_AXI_ARSIZE out 3; M_AXI_ARBURST out 2; M_AXI_ARCACHE out 4; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 64; M_AXI_RRESP in 2; M_AXI_RLAST in 1; M_AXI_RVALID in 1; M_AXI_RREADY out 1.
- M_AXIS_TDATA out 64; M_AXIS_TLAST out 1; M_AXIS_TVALID out 1; M_AXIS_TREADY in 1: data stream out.
- stat_bytes out 32; stat_cmds out 16: statistics (see Optional Feature).

Behaviour:
- Reset values: state IDLE, CMD_TREADY=1, ARVALID=0, STS_TVALID=0, internal error flags=0, stat counters=0.
  - RREADY/TVALID are 0 outside DATA state.
- Constants: ARSIZE=3'b011, ARBURST=2'b01, ARCACHE=C_CACHE, ARPROT=C_PROT.
- State IDLE: CMD_TREADY=1. On CMD_TVALID, latch addr, beats=BTT>>3, EOF, TAG; CMD_TREADY drops the next cycle.
  - If BTT==0, SADDR[2:0]!=0 or BTT[2:0]!=0: set INTERR and go to STATUS. No AXI traffic occurs.
  - Otherwise go to ADDR.
- State ADDR: burst length len = min(C_MAX_BURST, beats_left, (4096-addr[11:0])>>3), so no burst crosses a 4 KB boundary.
  - ARLEN=len-1. ARVALID asserts one cycle after entry and stays stable until ARREADY; then go to DATA.
- State DATA: pass-through. TVALID=RVALID, RREADY=TREADY, TDATA=RDATA, zero added latency. A beat counts only when RVALID&&RREADY.
  - TLAST=1 only on the final beat of the whole command, and only when EOF=1.
  - RRESP 2'b10 sets sticky SLVERR; 2'b11 sets sticky DECERR. Beats are still forwarded.
  - RLAST not coincident with the expected last burst beat (early or missing) sets INTERR. The burst still ends by the counter.
  - After the burst's last beat: addr += len*8, beats_left -= len. Go to ADDR if beats_left!=0, else STATUS.
- State STATUS: STS_TVALID=1, with OKAY = !(SLVERR|DECERR|INTERR). Data is held stable until STS_TREADY.
  - Then clear the flags, assert CMD_TREADY and return to IDLE. A new command is not accepted before status is taken.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH. BTT max 2^23-1 bytes, i.e. up to 1,048,575 beats; the beat counter is 20 bits.
- rst mid-operation returns to IDLE the next edge and drops ARVALID/RREADY/STS_TVALID. In-flight AXI beats are not drained (rst is global to the ACP fabric).

Optional Feature:
- Macro ACP_MM2S_STATS_EN.
- Defined:
  - stat_bytes accumulates 8 per forwarded beat (wraps at 2^32).
  - stat_cmds increments on each accepted status handshake (wraps at 2^16).
  - Both clear on rst.
- Undefined: stat_bytes and stat_cmds are tied to 0 and no counter logic is generated.

Test Plan:
- Cmd BTT=64, SADDR=0x1000, TAG=5, EOF=1, always-ready slave/sink -> one AR with ARLEN=7, ARADDR=0x1000; 8 beats out, TLAST on beat 8; status 0x85.
- BTT=256 at SADDR=0x1FC0, C_MAX_BURST=16 -> ARs 0x1FC0/ARLEN=7, 0x2000/ARLEN=15, 0x2080/ARLEN=7; 32 beats total; status OKAY.
- BTT=12 (unaligned), TAG=3 -> no ARVALID ever; status 0x13.
- 4-beat read with RRESP=2'b10 on beat 2, TAG=1, EOF=0 -> all 4 beats forwarded, TLAST never high; status 0x41.
- Random TREADY/RVALID stalls plus STS_TREADY held low 10 cycles over BTT=128 -> data order preserved, CMD_TREADY low until status accepted; with ACP_MM2S_STATS_EN, stat_bytes=128 and stat_cmds=1.
- rst pulsed during DATA of a 16-beat burst -> next cycle ARVALID=0, RREADY=0, CMD_TREADY=1; a fresh command then completes normally.
